// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Brief    : One-at-a-time load/store sequencer onto an sram-like data bus
//             with alignment checks, lane steering and load extension.
//  Revision : 1.0
// ============================================================================
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [3:0]        ex_op_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [31:0]       ex_wdata_i,
    input  logic              flush_i,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [3:0]        data_wstrb_o,
    output logic [31:0]       data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [31:0]       data_rdata_i,
    output logic              wb_valid_o,
    output logic [31:0]       wb_rdata_o,
    output logic              exc_adel_o,
    output logic              exc_ades_o,
    output logic [ADDR_W-1:0] bad_addr_o
);

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              state_q;
    logic                cancel_q;
    logic [3:0]          op_q;
    logic [1:0]          lane_q;
    logic                req_q;
    logic                wr_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          wstrb_q;
    logic [31:0]         wdata_q;
    logic                wb_valid_q;
    logic [31:0]         wb_rdata_q;
    logic                adel_q;
    logic                ades_q;
    logic [ADDR_W-1:0]   bad_addr_q;

    logic                w_is_load;
    logic                w_is_store;
    logic                w_misalign;
    logic [1:0]          w_size;
    logic [3:0]          w_strb;
    logic [31:0]         w_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;

    // Decode of the offered op; only consumed in IDLE on an accepted handshake.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_misalign = 1'b0;
        w_size     = SZ_BYTE;
        w_strb     = 4'b0000;
        w_wdata    = 32'd0;
        case (ex_op_i)
            OP_LB, OP_LBU: begin
                w_is_load = 1'b1;
                w_size    = SZ_BYTE;
            end
            OP_LH, OP_LHU: begin
                w_is_load  = 1'b1;
                w_size     = SZ_HALF;
                w_misalign = ex_addr_i[0];
            end
            OP_LW: begin
                w_is_load  = 1'b1;
                w_size     = SZ_WORD;
                w_misalign = |ex_addr_i[1:0];
            end
            OP_SB: begin
                w_is_store = 1'b1;
                w_size     = SZ_BYTE;
                w_strb     = 4'b0001 << ex_addr_i[1:0];
                w_wdata    = {4{ex_wdata_i[7:0]}};
            end
            OP_SH: begin
                w_is_store = 1'b1;
                w_size     = SZ_HALF;
                w_misalign = ex_addr_i[0];
                w_strb     = 4'b0011 << {ex_addr_i[1], 1'b0};
                w_wdata    = {2{ex_wdata_i[15:0]}};
            end
            OP_SW: begin
                w_is_store = 1'b1;
                w_size     = SZ_WORD;
                w_misalign = |ex_addr_i[1:0];
                w_strb     = 4'b1111;
                w_wdata    = ex_wdata_i;
            end
            default: ;
        endcase
    end

    // Lane selection and extension of the returning load word.
    always_comb begin
        w_byte = 8'd0;
        case (lane_q)
            2'd0:    w_byte = data_rdata_i[7:0];
            2'd1:    w_byte = data_rdata_i[15:8];
            2'd2:    w_byte = data_rdata_i[23:16];
            default: w_byte = data_rdata_i[31:24];
        endcase
        w_half = lane_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        w_load = 32'd0;
        case (op_q)
            OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load = {24'd0, w_byte};
            OP_LH:   w_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load = {16'd0, w_half};
            OP_LW:   w_load = data_rdata_i;
            default: w_load = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cancel_q   <= 1'b0;
            op_q       <= 4'd0;
            lane_q     <= 2'd0;
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wstrb_q    <= 4'd0;
            wdata_q    <= 32'd0;
            wb_valid_q <= 1'b0;
            wb_rdata_q <= 32'd0;
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ex_valid_i && !flush_i) begin
                        if (w_misalign) begin
                            adel_q     <= w_is_load;
                            ades_q     <= w_is_store;
                            bad_addr_q <= ex_addr_i;
                        end else if (!w_is_load && !w_is_store) begin
                            wb_valid_q <= 1'b1;
                            wb_rdata_q <= 32'd0;
                        end else begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                            wr_q    <= w_is_store;
                            size_q  <= w_size;
                            addr_q  <= ex_addr_i;
                            wstrb_q <= w_strb;
                            wdata_q <= w_wdata;
                            op_q    <= ex_op_i;
                            lane_q  <= ex_addr_i[1:0];
                        end
                    end
                end
                ST_REQ: begin
                    // The request stays up through a flush; only the response is discarded.
                    if (flush_i) begin
                        cancel_q <= 1'b1;
                    end
                    if (data_addr_ok_i) begin
                        req_q   <= 1'b0;
                        state_q <= (cancel_q || flush_i) ? ST_DRAIN : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok_i) begin
                        state_q <= ST_IDLE;
                        if (!flush_i) begin
                            wb_valid_q <= 1'b1;
                            wb_rdata_q <= wr_q ? 32'd0 : w_load;
                        end
                    end else if (flush_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (data_data_ok_i) begin
                        state_q  <= ST_IDLE;
                        cancel_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ex_ready_o   = (state_q == ST_IDLE);
    assign data_req_o   = req_q;
    assign data_wr_o    = wr_q;
    assign data_size_o  = size_q;
    assign data_addr_o  = addr_q;
    assign data_wstrb_o = wstrb_q;
    assign data_wdata_o = wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rdata_o   = wb_rdata_q;
    assign exc_adel_o   = adel_q;
    assign exc_ades_o   = ades_q;
    assign bad_addr_o   = bad_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Brief    : Directed bench for mem_access_ctrl with a behavioural bus model.
//  Revision : 1.0
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic [3:0]  ex_op_i = 4'd0;
    logic [31:0] ex_addr_i = 32'd0;
    logic [31:0] ex_wdata_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o;
    logic [3:0]  data_wstrb_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i = 1'b0;
    logic        data_data_ok_i = 1'b0;
    logic [31:0] data_rdata_i = 32'd0;
    logic        wb_valid_o;
    logic [31:0] wb_rdata_o;
    logic        exc_adel_o;
    logic        exc_ades_o;
    logic [31:0] bad_addr_o;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ex_valid_i     (ex_valid_i),
        .ex_ready_o     (ex_ready_o),
        .ex_op_i        (ex_op_i),
        .ex_addr_i      (ex_addr_i),
        .ex_wdata_i     (ex_wdata_i),
        .flush_i        (flush_i),
        .data_req_o     (data_req_o),
        .data_wr_o      (data_wr_o),
        .data_size_o    (data_size_o),
        .data_addr_o    (data_addr_o),
        .data_wstrb_o   (data_wstrb_o),
        .data_wdata_o   (data_wdata_o),
        .data_addr_ok_i (data_addr_ok_i),
        .data_data_ok_i (data_data_ok_i),
        .data_rdata_i   (data_rdata_i),
        .wb_valid_o     (wb_valid_o),
        .wb_rdata_o     (wb_rdata_o),
        .exc_adel_o     (exc_adel_o),
        .exc_ades_o     (exc_ades_o),
        .bad_addr_o     (bad_addr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { int due; logic [31:0] data; } wb_t;
    typedef struct { int due; bit st; logic [31:0] addr; } exc_t;
    wb_t  wb_q[$];
    exc_t exc_q[$];

    bit          exp_ready = 1'b1;
    bit          exp_req   = 1'b0;
    bit          exp_wr    = 1'b0;
    logic [1:0]  exp_size  = 2'd0;
    logic [31:0] exp_addr  = 32'd0;
    logic [3:0]  exp_strb  = 4'd0;
    logic [31:0] exp_wd    = 32'd0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nbytes(input logic [3:0] op);
        case (op)
            4'h0, 4'h4, 4'h8: return 1;
            4'h1, 4'h5, 4'h9: return 2;
            4'h2, 4'hA:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit m_load(input logic [3:0] op);
        return (op == 4'h0) || (op == 4'h1) || (op == 4'h2) || (op == 4'h4) || (op == 4'h5);
    endfunction

    function automatic bit m_signed(input logic [3:0] op);
        return (op == 4'h0) || (op == 4'h1);
    endfunction

    function automatic bit m_misaligned(input logic [3:0] op, input logic [31:0] addr);
        int nb = nbytes(op);
        int off = int'(addr[1:0]);
        return (nb > 0) && ((off % nb) != 0);
    endfunction

    function automatic logic [3:0] m_strb(input logic [3:0] op, input logic [31:0] addr);
        int nb = nbytes(op);
        int v;
        if (m_load(op)) return 4'd0;
        v = ((1 << nb) - 1) << int'(addr[1:0]);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] w);
        case (nbytes(op))
            1:       return (w & 32'h000000FF) * 32'h01010101;
            2:       return (w & 32'h0000FFFF) * 32'h00010001;
            default: return w;
        endcase
    endfunction

    function automatic logic [1:0] m_size(input logic [3:0] op);
        int nb = nbytes(op);
        return (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [31:0] m_load_val(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int     nb  = nbytes(op);
        int     off = int'(addr[1:0]);
        longint one = 1;
        longint v;
        v = (longint'(rdata) >> (8 * off)) & ((one << (8 * nb)) - 1);
        if (m_signed(op) && v >= (one << (8 * nb - 1))) v = v - (one << (8 * nb));
        return v[31:0];
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        chk("ready", ex_ready_o, exp_ready);
        chk("req", data_req_o, exp_req);
        if (data_req_o && exp_req) begin
            chk("bus_ctl", {data_wr_o, data_size_o, data_addr_o, data_wstrb_o},
                           {exp_wr, exp_size, exp_addr, exp_strb});
            if (exp_wr) chk("bus_wdata", data_wdata_o, exp_wd);
        end
        if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
            chk("wb_valid", wb_valid_o, 1'b1);
            chk("wb_rdata", wb_rdata_o, wb_q[0].data);
            void'(wb_q.pop_front());
        end else begin
            chk("wb_idle", wb_valid_o, 1'b0);
        end
        if (exc_q.size() > 0 && exc_q[0].due == cyc) begin
            chk("exc_kind", {exc_adel_o, exc_ades_o}, {!exc_q[0].st, exc_q[0].st});
            chk("bad_addr", bad_addr_o, exc_q[0].addr);
            void'(exc_q.pop_front());
        end else begin
            chk("exc_idle", {exc_adel_o, exc_ades_o}, 2'b00);
        end
    end

    // fmode: 0 normal, 1 flush in 2nd REQ cycle, 2 flush in WAIT, 3 flush with data_ok, 4 flush at offer
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int adly, input int fmode, input bit lit_en,
                          input logic [31:0] lit_rd, input logic [3:0] lit_strb,
                          input logic [31:0] lit_wd);
        bit ld, sup, mis;
        int t_drive;
        @(negedge clk);
        ld  = m_load(op);
        sup = nbytes(op) > 0;
        mis = m_misaligned(op, addr);
        ex_valid_i = 1'b1; ex_op_i = op; ex_addr_i = addr; ex_wdata_i = wdata;
        t_drive = cyc;
        if (fmode == 4) begin
            flush_i = 1'b1;
            @(negedge clk);
            flush_i = 1'b0; ex_valid_i = 1'b0;
            return;
        end
        if (mis) exc_q.push_back('{due: cyc + 1, st: !ld, addr: addr});
        else if (!sup) wb_q.push_back('{due: cyc + 1, data: 32'd0});
        else begin
            exp_ready = 1'b0; exp_req = 1'b1; exp_wr = !ld;
            exp_size = m_size(op); exp_addr = addr;
            exp_strb = m_strb(op, addr); exp_wd = m_wdata(op, wdata);
        end
        @(negedge clk);
        ex_valid_i = 1'b0;
        if (mis || !sup) begin
            if (lit_en && mis) begin
                chk("lit_adel", exc_adel_o, ld);
                chk("lit_ades", exc_ades_o, !ld);
                chk("lit_bad_addr", bad_addr_o, lit_rd);
                chk("lit_no_req", data_req_o, 1'b0);
            end else if (lit_en) begin
                chk("lit_unsup_wb", {wb_valid_o, wb_rdata_o}, {1'b1, lit_rd});
            end
            return;
        end
        if (lit_en && !ld) begin
            chk("lit_wstrb", data_wstrb_o, lit_strb);
            chk("lit_wdata", data_wdata_o, lit_wd);
        end
        for (int i = 0; i < adly; i++) begin
            if (fmode == 1 && i == 1) flush_i = 1'b1;
            data_rdata_i = $urandom;
            @(negedge clk);
            flush_i = 1'b0;
        end
        data_addr_ok_i = 1'b1; exp_req = 1'b0;
        @(negedge clk);
        data_addr_ok_i = 1'b0;
        if (fmode == 2) begin
            flush_i = 1'b1;
            @(negedge clk);
            flush_i = 1'b0;
        end
        data_data_ok_i = 1'b1; data_rdata_i = rdata; exp_ready = 1'b1;
        if (fmode == 3) flush_i = 1'b1;
        if (fmode == 0) wb_q.push_back('{due: cyc + 1, data: ld ? m_load_val(op, addr, rdata) : 32'd0});
        @(negedge clk);
        data_data_ok_i = 1'b0; flush_i = 1'b0; data_rdata_i = $urandom;
        if (lit_en) begin
            chk("lit_wb", {wb_valid_o, wb_rdata_o}, {1'b1, lit_rd});
            if (adly == 0) chk("lit_latency", cyc - t_drive, 3);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", ex_ready_o, 1'b1);
        chk("rst_outs", {data_req_o, data_wr_o, data_size_o, data_addr_o, data_wstrb_o, data_wdata_o,
                         wb_valid_o, wb_rdata_o, exc_adel_o, exc_ades_o, bad_addr_o}, 0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(4'h0, 32'h1001, 32'h0, 32'h123480FF, 0, 0, 1, 32'hFFFFFF80, 4'h0, 32'h0);
        run_op(4'h4, 32'h1001, 32'h0, 32'h123480FF, 0, 0, 1, 32'h00000080, 4'h0, 32'h0);
        run_op(4'h1, 32'h0002, 32'h0, 32'h80017FFF, 0, 0, 1, 32'hFFFF8001, 4'h0, 32'h0);
        run_op(4'h5, 32'h0002, 32'h0, 32'h80017FFF, 0, 0, 1, 32'h00008001, 4'h0, 32'h0);
        run_op(4'h2, 32'h0004, 32'h0, 32'h80017FFF, 0, 0, 1, 32'h80017FFF, 4'h0, 32'h0);
        run_op(4'h8, 32'h1003, 32'hAB, 32'h0, 0, 0, 1, 32'h0, 4'b1000, 32'hABABABAB);
        run_op(4'h9, 32'h0002, 32'h1234, 32'h0, 0, 0, 1, 32'h0, 4'b1100, 32'h12341234);
        run_op(4'h2, 32'h0002, 32'h0, 32'h0, 0, 0, 1, 32'h2, 4'h0, 32'h0);
        run_op(4'h9, 32'h0001, 32'h0, 32'h0, 0, 0, 1, 32'h1, 4'h0, 32'h0);
        run_op(4'h3, 32'h0040, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'h0, 32'h0);

        // Lane sweep and wait-stated slave through the model only.
        for (int i = 0; i < 4; i++) begin
            run_op(4'h0, 32'h100 + i, 32'h0, 32'h7F80FF01, i, 0, 0, 0, 0, 0);
            run_op(4'h8, 32'h200 + i, 32'h5A0 + i, 32'h0, 1, 0, 0, 0, 0, 0);
        end
        run_op(4'h5, 32'h0006, 32'h0, 32'hC3A5_1234, 2, 0, 0, 0, 0, 0);
        run_op(4'hA, 32'h0008, 32'hDEADBEEF, 32'h0, 1, 0, 0, 0, 0, 0);
        run_op(4'h2, 32'h0003, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
        run_op(4'hA, 32'h000E, 32'h1, 32'h0, 0, 0, 0, 0, 0, 0);

        // Flush variants.
        run_op(4'hA, 32'h0010, 32'h11223344, 32'h0, 3, 1, 0, 0, 0, 0);
        run_op(4'h0, 32'h0003, 32'h0, 32'hFFFFFFFF, 0, 2, 0, 0, 0, 0);
        run_op(4'h1, 32'h0006, 32'h0, 32'h12345678, 1, 3, 0, 0, 0, 0);
        run_op(4'h2, 32'h0020, 32'h0, 32'h0, 0, 4, 0, 0, 0, 0);
        run_op(4'h2, 32'h0024, 32'h0, 32'hCAFEF00D, 0, 0, 1, 32'hCAFEF00D, 4'h0, 32'h0);

        // Reset asserted while waiting for data_ok.
        @(negedge clk);
        ex_valid_i = 1'b1; ex_op_i = 4'h2; ex_addr_i = 32'h8; ex_wdata_i = 32'h0;
        exp_ready = 1'b0; exp_req = 1'b1; exp_wr = 1'b0; exp_size = 2'd2;
        exp_addr = 32'h8; exp_strb = 4'd0;
        @(negedge clk);
        ex_valid_i = 1'b0; data_addr_ok_i = 1'b1; exp_req = 1'b0;
        @(negedge clk);
        data_addr_ok_i = 1'b0;
        resetn = 1'b0; exp_ready = 1'b1;
        #1;
        chk("rst_mid_req", data_req_o, 1'b0);
        chk("rst_mid_wb", wb_valid_o, 1'b0);
        chk("rst_mid_ready", ex_ready_o, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        run_op(4'h2, 32'h0004, 32'h0, 32'h0BADF00D, 0, 0, 1, 32'h0BADF00D, 4'h0, 32'h0);

        repeat (3) @(negedge clk);
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("exc_queue_drained", exc_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
